// File: rtl/key_event_queue_if.sv
// Key event queue bus: producer strobes, consumer handshake and display/status outputs.
interface key_event_queue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          key_valid;
    logic [3:0]    key_code;
    logic          key_held;
    logic          q_ready;
    logic          ovf_clr;
    logic          q_valid;
    logic [3:0]    q_data;
    logic [CW-1:0] q_count;
    logic [3:0]    digit_new;
    logic [3:0]    digit_old;
    logic          overflow;

    modport master (
        output key_valid, key_code, key_held, q_ready, ovf_clr,
        input  q_valid, q_data, q_count, digit_new, digit_old, overflow
    );

    modport slave (
        input  key_valid, key_code, key_held, q_ready, ovf_clr,
        output q_valid, q_data, q_count, digit_new, digit_old, overflow
    );
endinterface

// File: rtl/key_event_queue.sv
// Keypad event FIFO (first-word fall-through) with two-digit display history and sticky overflow.
// Optional macro KEY_REPEAT_FILTER_EN drops strobes until key_held has been seen low.
module key_event_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [3:0]  RESET_NEW = 4'h6,
    parameter logic [3:0]  RESET_OLD = 4'h1
) (
    input logic              clk,
    input logic              reset,
    key_event_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_ovf;
    logic [3:0]    r_new;
    logic [3:0]    r_old;
    logic [3:0]    r_mem [DEPTH];

    logic          w_accept;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nxt;

`ifdef KEY_REPEAT_FILTER_EN
    // Armed once key_held is seen low; the current edge counts as a sighting.
    logic r_armed;

    assign w_accept = bus.key_valid && (r_armed || !bus.key_held);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b1;
        end else if (w_accept) begin
            r_armed <= 1'b0;
        end else if (!bus.key_held) begin
            r_armed <= 1'b1;
        end
    end
`else
    assign w_accept = bus.key_valid;
`endif

    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = r_valid && bus.q_ready;
    assign w_push = w_accept && (!w_full || w_pop);
    assign w_drop = w_accept && w_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_new    <= RESET_NEW;
            r_old    <= RESET_OLD;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // A fresh drop wins over a same-edge clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_accept) begin
                r_old <= r_new;
                r_new <= bus.key_code;
            end
        end
    end

    // Storage carries no reset; contents are only observed while q_valid is high.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.key_code;
        end
    end

    assign bus.q_valid   = r_valid;
    assign bus.q_data    = r_mem[r_rd_ptr];
    assign bus.q_count   = r_count;
    assign bus.digit_new = r_new;
    assign bus.digit_old = r_old;
    assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_key_event_queue.sv
// Directed vector bench for key_event_queue (DEPTH=4, default reset digits 6/1).
module tb_key_event_queue;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    key_event_queue_if #(.DEPTH(4)) bus ();

    key_event_queue #(.DEPTH(4), .RESET_NEW(4'h6), .RESET_OLD(4'h1)) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [3:0] ed;
        int         ec;
        logic [3:0] en;
        logic [3:0] eo;
        logic       eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic kv, logic [3:0] code, logic rdy, logic clr, logic ev,
                                logic [3:0] ed, int ec, logic [3:0] en, logic [3:0] eo,
                                logic eovf);
        vec_t v;
        v.kv = kv; v.code = code; v.rdy = rdy; v.clr = clr; v.ev = ev; v.ed = ed;
        v.ec = ec; v.en = en; v.eo = eo; v.eovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic ev, input logic [3:0] ed, input int ec,
                             input logic [3:0] en, input logic [3:0] eo, input logic eovf);
        chk({tag, " q_valid"},   int'(bus.q_valid),   int'(ev));
        chk({tag, " q_count"},   int'(bus.q_count),   ec);
        chk({tag, " digit_new"}, int'(bus.digit_new), int'(en));
        chk({tag, " digit_old"}, int'(bus.digit_old), int'(eo));
        chk({tag, " overflow"},  int'(bus.overflow),  int'(eovf));
        if (ev) chk({tag, " q_data"}, int'(bus.q_data), int'(ed));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.key_held  = 1'b0;
        bus.q_ready   = 1'b0;
        bus.ovf_clr   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        idle_inputs();

        //      kv  code  rdy clr | ev  data cnt new  old  ovf
        tbl.push_back(mk(1, 4'h3, 0, 0, 1, 4'h3, 1, 4'h3, 4'h6, 0));
        tbl.push_back(mk(1, 4'h7, 0, 0, 1, 4'h3, 2, 4'h7, 4'h3, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'h7, 1, 4'h7, 4'h3, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 0, 4'h7, 4'h3, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 0, 4'h7, 4'h3, 0));
        tbl.push_back(mk(1, 4'hA, 0, 0, 1, 4'hA, 1, 4'hA, 4'h7, 0));
        tbl.push_back(mk(1, 4'hB, 0, 0, 1, 4'hA, 2, 4'hB, 4'hA, 0));
        tbl.push_back(mk(1, 4'hC, 0, 0, 1, 4'hA, 3, 4'hC, 4'hB, 0));
        tbl.push_back(mk(1, 4'hD, 0, 0, 1, 4'hA, 4, 4'hD, 4'hC, 0));
        tbl.push_back(mk(1, 4'hE, 0, 0, 1, 4'hA, 4, 4'hE, 4'hD, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'hB, 3, 4'hE, 4'hD, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'hC, 2, 4'hE, 4'hD, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'hD, 1, 4'hE, 4'hD, 1));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 0, 4'hE, 4'hD, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 0, 4'h0, 0, 4'hE, 4'hD, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 1, 4'h1, 1, 4'h1, 4'hE, 0));
        tbl.push_back(mk(1, 4'h2, 0, 0, 1, 4'h1, 2, 4'h2, 4'h1, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 1, 4'h1, 3, 4'h3, 4'h2, 0));
        tbl.push_back(mk(1, 4'h4, 0, 0, 1, 4'h1, 4, 4'h4, 4'h3, 0));
        tbl.push_back(mk(1, 4'h9, 1, 0, 1, 4'h2, 4, 4'h9, 4'h4, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'h3, 3, 4'h9, 4'h4, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'h4, 2, 4'h9, 4'h4, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'h9, 1, 4'h9, 4'h4, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 0, 4'h0, 0, 4'h9, 4'h4, 0));
        tbl.push_back(mk(1, 4'h5, 0, 0, 1, 4'h5, 1, 4'h5, 4'h9, 0));
        tbl.push_back(mk(1, 4'h6, 1, 0, 1, 4'h6, 1, 4'h6, 4'h5, 0));
        tbl.push_back(mk(1, 4'h1, 0, 0, 1, 4'h6, 2, 4'h1, 4'h6, 0));
        tbl.push_back(mk(1, 4'h2, 0, 0, 1, 4'h6, 3, 4'h2, 4'h1, 0));
        tbl.push_back(mk(1, 4'h3, 0, 0, 1, 4'h6, 4, 4'h3, 4'h2, 0));
        tbl.push_back(mk(1, 4'h4, 0, 1, 1, 4'h6, 4, 4'h4, 4'h3, 1));
        tbl.push_back(mk(0, 4'h0, 0, 1, 1, 4'h6, 4, 4'h4, 4'h3, 0));
        tbl.push_back(mk(0, 4'h0, 1, 0, 1, 4'h1, 3, 4'h4, 4'h3, 0));

        tick();
        rst_n = 1'b1;
        tick();
        chk_state("reset", 1'b0, 4'h0, 0, 4'h6, 4'h1, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            bus.key_valid = tbl[i].kv;
            bus.key_code  = tbl[i].code;
            bus.q_ready   = tbl[i].rdy;
            bus.ovf_clr   = tbl[i].clr;
            tick();
            chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec,
                      tbl[i].en, tbl[i].eo, tbl[i].eovf);
        end
        idle_inputs();

        // Asynchronous reset with three queued entries, observed before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 4'h0, 0, 4'h6, 4'h1, 1'b0);
        tick();
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h8;
        #2;
        rst_n = 1'b1;
        tick();
        chk_state("post_rst_strobe", 1'b1, 4'h8, 1, 4'h8, 4'h6, 1'b0);
        idle_inputs();

        // Held-key repeat strobes: filtered build keeps only the first.
        do_reset();
        bus.key_held = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.key_valid = 1'b1;
            bus.key_code  = 4'h5;
            tick();
            bus.key_valid = 1'b0;
            tick();
        end
`ifdef KEY_REPEAT_FILTER_EN
        chk_state("held_x3", 1'b1, 4'h5, 1, 4'h5, 4'h6, 1'b0);
`else
        chk_state("held_x3", 1'b1, 4'h5, 3, 4'h5, 4'h5, 1'b0);
`endif
        bus.key_held = 1'b0;
        tick();
        bus.key_held  = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        tick();
        bus.key_valid = 1'b0;
`ifdef KEY_REPEAT_FILTER_EN
        chk_state("rearmed", 1'b1, 4'h5, 2, 4'h5, 4'h5, 1'b0);
`else
        chk_state("rearmed", 1'b1, 4'h5, 4, 4'h5, 4'h5, 1'b0);
`endif
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_NEW, default 4'h6, meaning digit_new value after reset.
REQ-003 Parameter RESET_OLD, default 4'h1, meaning digit_old value after reset.
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port key_valid  input  1  one-cycle strobe, new decoded key (scanner enable).
REQ-007 Port key_code  input  4  decoded key value, qualified by key_valid.
REQ-008 Port key_held  input  1  high while any column reads pressed; used only under REQ-024.
REQ-009 Port q_ready  input  1  consumer accepts head entry this cycle.
REQ-010 Port ovf_clr  input  1  synchronous clear of overflow flag.
REQ-011 Port q_valid  output  1  FIFO non-empty.
REQ-012 Port q_data  output  4  head entry, first-word fall-through.
REQ-013 Port q_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 Port digit_new  output  4  most recent accepted key, display digit 1.
REQ-015 Port digit_old  output  4  previous accepted key, display digit 2.
REQ-016 Port overflow  output  1  sticky, an event was dropped at full.

Function
REQ-017 Accepted event = key_valid high at rising edge and not suppressed by REQ-024; SHALL update digit_old<=digit_new, digit_new<=key_code on that edge, independent of FIFO state.
REQ-018 Push: accepted event with q_count<DEPTH, or with q_count==DEPTH while pop occurs the same edge; writes key_code at write pointer.
REQ-019 Pop: q_valid && q_ready at rising edge; advances read pointer; q_ready ignored when empty.
REQ-020 Simultaneous push and pop SHALL leave q_count unchanged, including at full and at count 1; q_data then shows the next older entry, or the pushed entry if count was 1.
REQ-021 Push latency: entry written at edge N SHALL appear on q_data/q_valid after edge N when FIFO was empty; no combinational path key_code->q_data.
REQ-022 Accepted event at full without pop SHALL be dropped from FIFO, set overflow on that edge; digits still update per REQ-017.
REQ-023 Pointers SHALL wrap modulo DEPTH; q_count SHALL never exceed DEPTH or underflow below 0; ovf_clr and a new overflow on the same edge SHALL leave overflow set.

Configuration
REQ-024 Macro KEY_REPEAT_FILTER_EN: when defined, a key_valid SHALL be ignored (no digit update, no push, no overflow) unless key_held was sampled low on at least one edge since the last accepted event; first event after reset always accepted.
REQ-025 Without KEY_REPEAT_FILTER_EN every key_valid is accepted; key_held unused, no filter state synthesized.

Reset
REQ-026 reset low SHALL asynchronously force: digit_new=RESET_NEW, digit_old=RESET_OLD, q_count=0, q_valid=0, overflow=0, pointers=0, filter armed.
REQ-027 q_data after reset undefined but SHALL not be used while q_valid=0; FIFO storage needs no reset.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries; first edge after release behaves as a fresh start, including a key_valid present on that edge.

Verification
REQ-029 Reset release, no stimulus -> digit_new=6, digit_old=1, q_valid=0, q_count=0, overflow=0.
REQ-030 Strobes 3, 7 with q_ready=0 -> digit_new=7, digit_old=3, q_count=2, q_data=3; pop two cycles -> q_data 7 then q_valid=0.
REQ-031 Five strobes A,B,C,D,E, q_ready=0, DEPTH=4 -> q_count=4, overflow=1, digit_new=E, pops return A,B,C,D; ovf_clr -> overflow=0.
REQ-032 At full, key_valid and q_ready same edge with code 9 -> q_count stays 4, last popped-in entry 9 emerges fourth.
REQ-033 KEY_REPEAT_FILTER_EN defined: key_held=1 throughout, strobes 5,5,5 -> one entry, digit_new=5; drop key_held one cycle, strobe 5 -> second entry; undefined build -> three entries.
REQ-034 Reset pulsed with q_count=3 -> q_count=0, digits to 6/1 immediately (asynchronously), before next clock edge.
